// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and types for the register-file writeback arbiter
package regfile_pkg;
   localparam int DW_DEFAULT    = 32;
   localparam int AW_DEFAULT    = 5;
   localparam int DEPTH_DEFAULT = 2;

   typedef struct packed {
      logic [AW_DEFAULT-1:0] addr;
      logic [DW_DEFAULT-1:0] data;
   } wb_entry_t;

   typedef enum logic {
      RR_Q0 = 1'b0,
      RR_Q1 = 1'b1
   } rr_sel_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - requester handshakes, register-file write port and pending mask
interface regfile_wb_arbiter_if
   import regfile_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int AW = AW_DEFAULT
);
   logic                req0_valid;
   logic [AW-1:0]       req0_addr;
   logic [DW-1:0]       req0_data;
   logic                req0_ready;
   logic                req1_valid;
   logic [AW-1:0]       req1_addr;
   logic [DW-1:0]       req1_data;
   logic                req1_ready;
   logic                rf_we;
   logic [AW-1:0]       rf_waddr;
   logic [DW-1:0]       rf_wdata;
   logic [(1<<AW)-1:0]  pending_mask;

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  rf_we, rf_waddr, rf_wdata, pending_mask
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output rf_we, rf_waddr, rf_wdata, pending_mask
   );
endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small circular writeback queue exposing per-slot valid and address
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int AW    = AW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [AW-1:0]              push_addr,
   input  logic [DW-1:0]              push_data,
   input  logic                       pop,
   output logic [AW-1:0]              head_addr,
   output logic [DW-1:0]              head_data,
   output logic                       full,
   output logic                       empty,
   output logic [DEPTH-1:0]           entry_valid,
   output logic [DEPTH-1:0][AW-1:0]   entry_addr
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PW-1:0]            wr_ptr;
   logic [PW-1:0]            rd_ptr;
   logic [DEPTH-1:0]         slot_valid;
   logic [DEPTH-1:0][AW-1:0] mem_addr;
   logic [DEPTH-1:0][DW-1:0] mem_data;
   logic                     do_push;
   logic                     do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   // Gated here so a push and pop can never target the same slot.
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         slot_valid <= '0;
      end else begin
         if (do_push) begin
            slot_valid[wr_ptr] <= 1'b1;
            wr_ptr             <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            slot_valid[rd_ptr] <= 1'b0;
            rd_ptr             <= ptr_inc(rd_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_addr[wr_ptr] <= push_addr;
         mem_data[wr_ptr] <= push_data;
      end
   end

   assign head_addr   = mem_addr[rd_ptr];
   assign head_data   = mem_data[rd_ptr];
   assign full        = &slot_valid;
   assign empty       = ~|slot_valid;
   assign entry_valid = slot_valid;
   assign entry_addr  = mem_addr;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin merge of two writeback queues onto one register-file write port
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DW    = DW_DEFAULT,
   parameter int AW    = AW_DEFAULT,
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   regfile_wb_arbiter_if.slave  bus
);
   logic                     push0, push1, pop0, pop1;
   logic                     full0, full1, empty0, empty1;
   logic [AW-1:0]            head_addr0, head_addr1;
   logic [DW-1:0]            head_data0, head_data1;
   logic [DEPTH-1:0]         ev0, ev1;
   logic [DEPTH-1:0][AW-1:0] ea0, ea1;
   rr_sel_t                  rr_q, rr_d;
   logic                     we_q;
   logic [AW-1:0]            waddr_q;
   logic [DW-1:0]            wdata_q;
   logic [(1<<AW)-1:0]       mask;

   assign bus.req0_ready = ~full0;
   assign bus.req1_ready = ~full1;
   assign push0 = bus.req0_valid & ~full0;
   assign push1 = bus.req1_valid & ~full1;

   wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo0 (
      .clk(clk), .reset(reset), .push(push0), .push_addr(bus.req0_addr),
      .push_data(bus.req0_data), .pop(pop0), .head_addr(head_addr0),
      .head_data(head_data0), .full(full0), .empty(empty0),
      .entry_valid(ev0), .entry_addr(ea0)
   );

   wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo1 (
      .clk(clk), .reset(reset), .push(push1), .push_addr(bus.req1_addr),
      .push_data(bus.req1_data), .pop(pop1), .head_addr(head_addr1),
      .head_data(head_data1), .full(full1), .empty(empty1),
      .entry_valid(ev1), .entry_addr(ea1)
   );

   always_ff @(posedge clk) begin
      if (reset) rr_q <= RR_Q0;
      else       rr_q <= rr_d;
   end

   // Preferred queue wins when non-empty; otherwise the other one is drained.
   always_comb begin
      pop0 = 1'b0;
      pop1 = 1'b0;
      rr_d = rr_q;
      if (rr_q == RR_Q0) begin
         if (!empty0)      pop0 = 1'b1;
         else if (!empty1) pop1 = 1'b1;
      end else begin
         if (!empty1)      pop1 = 1'b1;
         else if (!empty0) pop0 = 1'b1;
      end
      if (pop0) rr_d = RR_Q1;
      if (pop1) rr_d = RR_Q0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else if (pop0) begin
         we_q    <= (head_addr0 != '0);
         waddr_q <= head_addr0;
         wdata_q <= head_data0;
      end else if (pop1) begin
         we_q    <= (head_addr1 != '0);
         waddr_q <= head_addr1;
         wdata_q <= head_data1;
      end else begin
         we_q    <= 1'b0;
      end
   end

   // Register 0 is hardwired, so it is never reported as pending.
   always_comb begin
      mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ev0[i] && (ea0[i] != '0)) mask[ea0[i]] = 1'b1;
         if (ev1[i] && (ea1[i] != '0)) mask[ea1[i]] = 1'b1;
      end
      if (we_q) mask[waddr_q] = 1'b1;
   end

   assign bus.rf_we        = we_q;
   assign bus.rf_waddr     = waddr_q;
   assign bus.rf_wdata     = wdata_q;
   assign bus.pending_mask = mask;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed and randomized checks against a queue-level reference model
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   localparam int DEPTH = DEPTH_DEFAULT;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

   regfile_wb_arbiter #(.DW(32), .AW(5), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [31:0] tb_rf [32];
   always @(posedge clk) begin
      if (bus.rf_we === 1'b1) tb_rf[bus.rf_waddr] <= bus.rf_wdata;
   end

   wb_entry_t   q0[$];
   wb_entry_t   q1[$];
   int          rr;
   logic        exp_we;
   logic [4:0]  exp_waddr;
   logic [31:0] exp_wdata;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_mask();
      logic [31:0] m;
      m = '0;
      foreach (q0[i]) if (q0[i].addr != 0) m[q0[i].addr] = 1'b1;
      foreach (q1[i]) if (q1[i].addr != 0) m[q1[i].addr] = 1'b1;
      if (exp_we) m[exp_waddr] = 1'b1;
      return m;
   endfunction

   task automatic model_edge();
      bit        r0, r1;
      int        pick;
      wb_entry_t e;
      if (reset) begin
         q0.delete(); q1.delete();
         rr = 0; exp_we = 0; exp_waddr = '0; exp_wdata = '0;
         return;
      end
      r0 = q0.size() < DEPTH;
      r1 = q1.size() < DEPTH;
      pick = -1;
      if (rr == 0) pick = (q0.size() > 0) ? 0 : ((q1.size() > 0) ? 1 : -1);
      else         pick = (q1.size() > 0) ? 1 : ((q0.size() > 0) ? 0 : -1);
      exp_we = 1'b0;
      if (pick >= 0) begin
         e = (pick == 0) ? q0.pop_front() : q1.pop_front();
         exp_we    = (e.addr != 0);
         exp_waddr = e.addr;
         exp_wdata = e.data;
         rr        = 1 - pick;
      end
      if (bus.req0_valid && r0) begin
         e.addr = bus.req0_addr; e.data = bus.req0_data; q0.push_back(e);
      end
      if (bus.req1_valid && r1) begin
         e.addr = bus.req1_addr; e.data = bus.req1_data; q1.push_back(e);
      end
   endtask

   task automatic cycle();
      model_edge();
      @(posedge clk);
      #1;
      chk("rf_we",        bus.rf_we,        exp_we);
      chk("rf_waddr",     bus.rf_waddr,     exp_waddr);
      chk("rf_wdata",     bus.rf_wdata,     exp_wdata);
      chk("req0_ready",   bus.req0_ready,   q0.size() < DEPTH);
      chk("req1_ready",   bus.req1_ready,   q1.size() < DEPTH);
      chk("pending_mask", bus.pending_mask, exp_mask());
   endtask

   task automatic drive0(input bit v, input logic [4:0] a, input logic [31:0] d);
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
   endtask

   task automatic drive1(input bit v, input logic [4:0] a, input logic [31:0] d);
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
   endtask

   initial begin
      int   idx0, idx1, na, nb, lo0, lo1;
      logic rdy0, rdy1;
      logic [3:0] exp_src;

      reset = 1'b1;
      drive0(0, 0, 0);
      drive1(0, 0, 0);
      rr = 0; exp_we = 0; exp_waddr = 0; exp_wdata = 0;
      cycle(); cycle();
      reset = 1'b0;
      chk("rst_ready0", bus.req0_ready, 1);
      chk("rst_ready1", bus.req1_ready, 1);
      chk("rst_pending", bus.pending_mask, 0);
      chk("rst_we", bus.rf_we, 0);
      chk("rst_waddr", bus.rf_waddr, 0);
      chk("rst_wdata", bus.rf_wdata, 0);

      // single write latency and pending lifetime
      drive0(1, 3, 32'h11);
      cycle();
      drive0(0, 0, 0);
      chk("lat_pend_e1", bus.pending_mask[3], 1);
      cycle();
      chk("lat_we_e2", bus.rf_we, 1);
      chk("lat_waddr_e2", bus.rf_waddr, 3);
      chk("lat_wdata_e2", bus.rf_wdata, 32'h11);
      chk("lat_pend_e2", bus.pending_mask[3], 1);
      cycle();
      chk("lat_pend_e3", bus.pending_mask[3], 0);

      // address 0 is consumed silently
      drive0(1, 0, 32'hFF);
      cycle();
      drive0(0, 0, 0);
      chk("a0_pend_e1", bus.pending_mask, 0);
      cycle();
      chk("a0_we", bus.rf_we, 0);
      chk("a0_pend_e2", bus.pending_mask, 0);

      // same-address collision from both requesters
      reset = 1'b1; cycle(); reset = 1'b0;
      drive0(1, 7, 32'h1);
      drive1(1, 7, 32'h2);
      cycle();
      drive0(0, 0, 0); drive1(0, 0, 0);
      cycle();
      chk("col_first", bus.rf_wdata, 32'h1);
      cycle();
      chk("col_second", bus.rf_wdata, 32'h2);
      chk("col_rf_mid", tb_rf[7], 32'h1);
      cycle();
      chk("col_rf_end", tb_rf[7], 32'h2);

      // saturating traffic on both requesters
      reset = 1'b1; cycle(); reset = 1'b0;
      idx0 = 0; idx1 = 0; na = 0; nb = 0; lo0 = 0; lo1 = 0; exp_src = 4'hA;
      for (int i = 0; i < 14; i++) begin
         drive0(1, 5, 32'hA0 + idx0);
         drive1(1, 9, 32'hB0 + idx1);
         rdy0 = bus.req0_ready;
         rdy1 = bus.req1_ready;
         cycle();
         if (rdy0) idx0++;
         if (rdy1) idx1++;
         if (i == 1) chk("bp_third_held", bus.req1_ready, 0);
         if (i == 2) chk("bp_released", bus.req1_ready, 1);
         lo0 = bus.req0_ready ? 0 : lo0 + 1;
         lo1 = bus.req1_ready ? 0 : lo1 + 1;
         chk("stuck0", lo0 <= 1, 1);
         chk("stuck1", lo1 <= 1, 1);
         if (bus.rf_we === 1'b1) begin
            chk("alt_src", bus.rf_wdata[7:4], exp_src);
            if (bus.rf_wdata[7:4] == 4'hA) begin
               chk("order_a", bus.rf_wdata, 32'hA0 + na); na++;
            end else begin
               chk("order_b", bus.rf_wdata, 32'hB0 + nb); nb++;
            end
            exp_src = (exp_src == 4'hA) ? 4'hB : 4'hA;
         end
      end

      // reset with queues loaded
      reset = 1'b1; cycle(); reset = 1'b0;
      drive0(0, 0, 0); drive1(0, 0, 0);
      chk("mid_rst_we", bus.rf_we, 0);
      chk("mid_rst_pend", bus.pending_mask, 0);
      chk("mid_rst_rdy0", bus.req0_ready, 1);
      chk("mid_rst_rdy1", bus.req1_ready, 1);
      cycle();
      chk("mid_rst_idle", bus.rf_we, 0);
      drive0(1, 2, 32'h33);
      drive1(1, 4, 32'h44);
      cycle();
      drive0(0, 0, 0); drive1(0, 0, 0);
      cycle();
      chk("ptr_q0_first", bus.rf_waddr, 2);
      cycle();
      chk("ptr_q1_next", bus.rf_waddr, 4);

      // randomized traffic honouring the hold-until-transfer rule
      for (int i = 0; i < 400; i++) begin
         if (!bus.req0_valid && $urandom_range(0, 3) != 0)
            drive0(1, 5'($urandom_range(0, 7)), $urandom);
         if (!bus.req1_valid && $urandom_range(0, 3) != 0)
            drive1(1, 5'($urandom_range(0, 7)), $urandom);
         reset = ($urandom_range(0, 63) == 0);
         rdy0 = bus.req0_ready;
         rdy1 = bus.req1_ready;
         cycle();
         if (bus.req0_valid && rdy0 && !reset) bus.req0_valid = 1'b0;
         if (bus.req1_valid && rdy1 && !reset) bus.req1_valid = 1'b0;
         reset = 1'b0;
      end
      drive0(0, 0, 0); drive1(0, 0, 0);
      for (int i = 0; i < 6; i++) cycle();
      chk("drain_pend", bus.pending_mask, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DW, default 32, data width of one register.
REQ-002 Parameter: AW, default 5, register address width (32 registers).
REQ-003 Parameter: DEPTH, default 2, entries per requester queue.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0_valid  input  1  requester 0 (ALU writeback) has a write.
REQ-007 req0_addr  input  AW  requester 0 destination register.
REQ-008 req0_data  input  DW  requester 0 write data.
REQ-009 req0_ready  output  1  requester 0 queue can accept.
REQ-010 req1_valid / req1_addr / req1_data / req1_ready: same as REQ-006..009, for requester 1 (load writeback).
REQ-011 rf_we  output  1  write enable to register file.
REQ-012 rf_waddr  output  AW  write address to register file.
REQ-013 rf_wdata  output  DW  write data to register file.
REQ-014 pending_mask  output  2**AW  bit n set = uncommitted write to register n in flight.

Function
REQ-015 Transfer on reqN occurs at a rising edge where reqN_valid and reqN_ready are both 1; the entry is pushed into queue N.
REQ-016 reqN_ready shall be 1 exactly when queue N holds fewer than DEPTH entries; it shall not depend on same-cycle pops or on reqN_valid.
REQ-017 Requesters shall hold valid/addr/data stable until transfer; the block shall not assume this for correctness of its own state.
REQ-018 Each edge, if any queue is non-empty, the arbiter pops exactly one head, chosen round-robin: pointer names the preferred queue; if it is empty, the other is taken.
REQ-019 After a grant to queue N, the pointer shall move to the other queue; with no grant the pointer holds.
REQ-020 The popped entry loads output registers: rf_we=1 (0 if addr==0), rf_waddr=addr, rf_wdata=data; with no pop, rf_we=0 and rf_waddr/rf_wdata hold their last values.
REQ-021 Latency: entry transferred at edge E into an empty queue, if granted, drives rf_we during the cycle after edge E+1; the register file commits it at edge E+2.
REQ-022 Order within one requester shall be preserved; order between requesters is grant order only.
REQ-023 Writes to address 0 shall be accepted and consumed but never raise rf_we nor set pending_mask bit 0.
REQ-024 pending_mask bit n = OR over all valid queue entries and the output register (when rf_we=1) whose addr==n; combinational from state, no input-to-output path.
REQ-025 Simultaneous push and pop on one queue in the same edge shall both take effect; occupancy unchanged.
REQ-026 Full queue: a push attempt (valid=1, ready=0) shall be ignored with no state change.
REQ-027 Both heads targeting the same address: both writes are issued, in grant order; the last granted value remains in the register.

Reset
REQ-028 While reset=1 at an edge: both queues emptied, round-robin pointer = queue 0, rf_we=0, rf_waddr=0, rf_wdata=0.
REQ-029 Consequently, after reset: req0_ready=req1_ready=1, pending_mask=0.
REQ-030 Reset asserted mid-operation shall discard all queued and output-stage writes; no write issues at the edge where reset=1.

Structure
REQ-031 Package regfile_pkg shall hold DW, AW, DEPTH defaults and the queue-entry type (addr, data).
REQ-032 One sub-module, wb_fifo: parameterised synchronous FIFO with push/pop, full/empty, per-entry valid and addr visibility; instantiated twice.

Verification
REQ-033 Reset, then req0 writes addr 3 data 0x11 at edge 1 -> rf_we=1, waddr=3, wdata=0x11 after edge 2; pending_mask bit 3 set after edges 1 and 2, clear after edge 3.
REQ-034 Both requesters valid every cycle, req0 data 0xA0.., req1 data 0xB0.. -> grants alternate 0,1,0,1; each stream's data in order; neither ready stuck low more than 1 cycle.
REQ-035 req1 valid, drain stalled by req0 traffic, 3 back-to-back pushes -> third push held (ready=0) until a pop; no entry lost or duplicated.
REQ-036 req0 writes addr 0 data 0xFF -> accepted, rf_we stays 0, pending_mask stays 0.
REQ-037 req0 and req1 both write addr 7 (0x1, 0x2) same edge, pointer at 0 -> rf writes 0x1 then 0x2; register 7 ends 0x2.
REQ-038 Both queues full, reset asserted one cycle -> rf_we=0 next cycle, pending_mask=0, both ready=1, pointer at 0.
